// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Fetch-side lookup is combinational; execute-side resolution writes back one entry per edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateEnE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [31:0] PCE,
  input  logic        ActTakenE,
  input  logic [31:0] ActTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             res_active;

  logic             ent_we_d;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [31:0]      ent_target_d;
  logic [1:0]       ent_ctr_d;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // Fetch lookup; reads the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    if (!rst && hit_f && ctr_q[idx_f][1]) begin
      PredTakenF  = 1'b1;
      PredTargetF = target_q[idx_f];
    end else begin
      PredTakenF  = 1'b0;
      PredTargetF = PCF + 32'd4;
    end
  end

  // Execute-side resolution and redirect.
  always_comb begin
    res_active = UpdateEnE && (BranchE || JumpE);
    CorrectPCE = ActTakenE ? ActTargetE : (PCE + 32'd4);
    if (res_active) begin
      MispredictE = (PredTakenE != ActTakenE) ||
                    (PredTakenE && ActTakenE && (PredTargetE != ActTargetE));
    end else begin
      MispredictE = 1'b0;
    end
  end

  // Next contents of the single entry addressed by PCE; JumpE dominates BranchE.
  always_comb begin
    hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ent_we_d     = 1'b0;
    ent_valid_d  = valid_q[idx_e];
    ent_tag_d    = tag_q[idx_e];
    ent_target_d = target_q[idx_e];
    ent_ctr_d    = ctr_q[idx_e];
    if (res_active) begin
      if (hit_e) begin
        ent_we_d = 1'b1;
        if (JumpE) begin
          ent_ctr_d = 2'd3;
        end else if (ActTakenE) begin
          ent_ctr_d = ctr_inc(ctr_q[idx_e]);
        end else begin
          ent_ctr_d = ctr_dec(ctr_q[idx_e]);
        end
        if (ActTakenE) begin
          ent_target_d = ActTargetE;
        end else begin
          ent_target_d = target_q[idx_e];
        end
      end else if (ActTakenE) begin
        ent_we_d     = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = tag_e;
        ent_target_d = ActTargetE;
        ent_ctr_d    = JumpE ? 2'd3 : 2'd2;
      end else begin
        ent_we_d = 1'b0;
      end
    end else begin
      ent_we_d = 1'b0;
    end
  end

  // Saturating statistics.
  always_comb begin
    if (res_active) begin
      bcnt_d = sat_inc32(bcnt_q);
    end else begin
      bcnt_d = bcnt_q;
    end
    if (MispredictE) begin
      mcnt_d = sat_inc32(mcnt_q);
    end else begin
      mcnt_d = mcnt_q;
    end
  end

  // Table and counter state; reset clears everything and blocks any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'd1;
      end
      bcnt_q <= 32'd0;
      mcnt_q <= 32'd0;
    end else begin
      if (ent_we_d) begin
        valid_q[idx_e]  <= ent_valid_d;
        tag_q[idx_e]    <= ent_tag_d;
        target_q[idx_e] <= ent_target_d;
        ctr_q[idx_e]    <= ent_ctr_d;
      end
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  // Counters read as cleared for the whole time reset is held.
  assign BranchCount  = rst ? 32'd0 : bcnt_q;
  assign MispredCount = rst ? 32'd0 : mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a per-index table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateEnE, BranchE, JumpE;
  logic [31:0] PCE;
  logic        ActTakenE;
  logic [31:0] ActTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE, BranchCount, MispredCount;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateEnE(UpdateEnE), .BranchE(BranchE), .JumpE(JumpE), .PCE(PCE),
    .ActTakenE(ActTakenE), .ActTargetE(ActTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE), .CorrectPCE(CorrectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  // Reference table: one slot per index, tag kept as the full upper PC bits.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  longint      m_bcnt, m_mcnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
    int i;
    i = int'((pc >> 2) % 32'd16);
    if (m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2) begin
      taken = 1'b1; tgt = m_target[i];
    end else begin
      taken = 1'b0; tgt = pc + 32'd4;
    end
  endtask

  task automatic step(input logic [31:0] pcf, input bit upd, input bit br, input bit jmp,
                      input logic [31:0] pce, input bit at, input logic [31:0] atg,
                      input bit pt, input logic [31:0] ptg, input bit r);
    bit          e_pt, active, mis, hit;
    logic [31:0] e_tgt;
    int          i;
    rst = r; PCF = pcf; UpdateEnE = upd; BranchE = br; JumpE = jmp; PCE = pce;
    ActTakenE = at; ActTargetE = atg; PredTakenE = pt; PredTargetE = ptg;
    #1;
    if (r) begin
      e_pt = 1'b0; e_tgt = pcf + 32'd4;
    end else begin
      model_predict(pcf, e_pt, e_tgt);
    end
    active = upd && (br || jmp);
    mis = active && ((pt != at) || (pt && at && ptg != atg));
    chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, e_pt});
    chk("PredTargetF", PredTargetF, e_tgt);
    chk("CorrectPCE", CorrectPCE, at ? atg : pce + 32'd4);
    chk("BranchCount", BranchCount, r ? 32'd0 : 32'(m_bcnt));
    chk("MispredCount", MispredCount, r ? 32'd0 : 32'(m_mcnt));
    if (!r) chk("MispredictE", {31'd0, MispredictE}, {31'd0, mis});
    vectors++;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (active) begin
      if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
      if (mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      i = int'((pce >> 2) % 32'd16);
      hit = m_valid[i] && m_tag[i] == (pce >> 6);
      if (hit) begin
        if (jmp) m_ctr[i] = 3;
        else if (at) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        if (at) m_target[i] = atg;
      end else if (at) begin
        m_valid[i] = 1'b1; m_tag[i] = pce >> 6; m_target[i] = atg; m_ctr[i] = jmp ? 3 : 2;
      end
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] pcf);
    step(pcf, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    bit          rp, rj, ra;
    logic [31:0] rpce, rtgt, rpt;
    model_reset();
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    step(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    lookup(32'h100);
    // Taken branch, mispredicted; same-cycle lookup still sees the miss.
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
    lookup(32'h100);
    // Three not-taken resolutions: 2->1->0->0, then one taken leaves ctr at 1.
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
    lookup(32'h100);
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0);
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0);
    step(32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
    lookup(32'h100);
    // jalr at 0x200 retargeted from 0x400 to 0x500.
    step(32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 1'b0);
    lookup(32'h200);
    step(32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 32'h400, 1'b0);
    lookup(32'h200);
    // Aliasing at index 0.
    step(32'h0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
    step(32'h0, 1'b1, 1'b1, 1'b0, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144, 1'b0);
    lookup(32'h100);
    lookup(32'h140);
    lookup(32'hFFFF_FFFC);
    // Branch and jump both set: treated as a jump, allocated with ctr 3.
    step(32'h0, 1'b1, 1'b1, 1'b1, 32'h124, 1'b1, 32'h600, 1'b0, 32'h128, 1'b0);
    step(32'h124, 1'b1, 1'b1, 1'b0, 32'h124, 1'b0, 32'h600, 1'b1, 32'h600, 1'b0);
    lookup(32'h124);
    // Reset during an active resolution.
    step(32'h140, 1'b1, 1'b1, 1'b0, 32'h180, 1'b1, 32'h900, 1'b0, 32'h184, 1'b1);
    lookup(32'h140);
    lookup(32'h180);

    for (int n = 0; n < 600; n++) begin
      rpce = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      rtgt = 32'($urandom_range(0, 1023)) << 2;
      rj = ($urandom_range(0, 4) == 0);
      ra = rj ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        model_predict(rpce, rp, rpt);
      end else begin
        rp = 1'($urandom_range(0, 1));
        rpt = 32'($urandom_range(0, 1023)) << 2;
      end
      step(($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
             : (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0), rj, rpce, ra, rtgt,
           rp, rpt, ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
